// File: rtl/uart_tx_rx_loopback.sv
// 8N1 UART transmitter and receiver joined by an internal serial line.
// Bring-up vehicle: proves TX framing and RX baud timing agree without pins.
//
// TX state | meaning
// ---------+-----------------------------------------------
// IDLE     | line high, waiting for TX_ENA
// START    | driving start bit (0) for one bit period
// DATA     | driving data bits LSB first, one bit period each
// STOP     | driving stop bit (1), TX_DONE set on exit
//
// RX state | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for the line to fall
// START    | half-bit wait, confirm start bit at mid-bit
// DATA     | sampling 8 data bits at mid-bit
// STOP     | sampling stop bit, load RX_DOUT if valid
// REST     | waiting out the rest of the stop bit
module uart_tx_rx_loopback #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DIN,
    input  logic       TX_ENA,
    output logic       TX_DONE,
    output logic       RX_DONE,
    output logic [7:0] RX_DOUT
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_REM  = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_REST  = 3'd4;

    logic [1:0]       r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_idx;
    logic [7:0]       r_tx_shift;
    logic             r_tx_line;
    logic             r_tx_done;

    logic [2:0]       r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_idx;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_dout;
    logic             r_rx_done;

    logic             w_line;

    assign w_line  = r_tx_line;
    assign TX_DONE = r_tx_done;
    assign RX_DONE = r_rx_done;
    assign RX_DOUT = r_rx_dout;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_line <= 1'b1;
                    if (TX_ENA) begin
                        r_tx_shift <= TX_DIN;
                        r_tx_done  <= 1'b0;
                        r_tx_line  <= 1'b0;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end else begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_idx   <= '0;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end else begin
                        r_tx_cnt <= BIT_LAST;
                        if (r_tx_idx == 3'd7) begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end else begin
                        r_tx_done  <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX returns to IDLE before the stop bit ends so a frame accepted right
    // after TX_DONE still has its start edge seen.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_dout  <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_line) begin
                        r_rx_done  <= 1'b0;
                        r_rx_cnt   <= HALF_LAST;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end else if (!w_line) begin
                        r_rx_idx   <= '0;
                        r_rx_cnt   <= BIT_LAST;
                        r_rx_state <= RX_DATA;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end else begin
                        r_rx_shift <= {w_line, r_rx_shift[7:1]};
                        r_rx_cnt   <= BIT_LAST;
                        if (r_rx_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end else begin
                        if (w_line) begin
                            r_rx_dout <= r_rx_shift;
                            r_rx_done <= 1'b1;
                        end
                        r_rx_cnt   <= STOP_REM;
                        r_rx_state <= RX_REST;
                    end
                end
                RX_REST: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_rx_loopback.sv
// Directed bench for uart_tx_rx_loopback: framing, back-to-back frames,
// ignored mid-frame requests, reset abort and stop-bit framing error.
module tb_uart_tx_rx_loopback;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] TX_DIN = 8'h00;
    logic       TX_ENA = 1'b0;
    logic       TX_DONE;
    logic       RX_DONE;
    logic [7:0] RX_DOUT;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    uart_tx_rx_loopback #(.CLKS_PER_BIT(CPB)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .TX_DIN  (TX_DIN),
        .TX_ENA  (TX_ENA),
        .TX_DONE (TX_DONE),
        .RX_DONE (RX_DONE),
        .RX_DOUT (RX_DOUT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    task automatic run_frame(input logic [7:0] b, input bit mid_ena, input bit inj_err,
                             input logic [7:0] exp_dout, input logic exp_rxd);
        logic [9:0] frame;
        int         n;
        frame  = {1'b1, b, 1'b0};
        TX_DIN = b;
        TX_ENA = 1'b1;
        @(negedge CLK);
        TX_ENA = 1'b0;
        n = 1;
        chk($sformatf("tx_done_clr_%0h", b), TX_DONE, 1'b0);
        while (!TX_DONE && n < 400) begin
            @(negedge CLK);
            n++;
            if (n == 3)
                chk($sformatf("rx_done_clr_%0h", b), RX_DONE, 1'b0);
            if ((n % CPB) == CPB / 2 && n < 10 * CPB && !(inj_err && (n / CPB) == 9))
                chk($sformatf("line_%0h_b%0d", b, n / CPB), dut.w_line, frame[n / CPB]);
            if (mid_ena && n == 4 * CPB) begin
                TX_DIN = ~b;
                TX_ENA = 1'b1;
            end
            if (mid_ena && n == 4 * CPB + 1)
                TX_ENA = 1'b0;
            if (inj_err && n == 9 * CPB + 2)
                force dut.w_line = 1'b0;
            if (inj_err && n == 10 * CPB - 2)
                release dut.w_line;
            if (n == 10 * CPB - 4)
                chk($sformatf("rx_before_tx_%0h", b), RX_DONE, exp_rxd);
        end
        chk($sformatf("tx_latency_%0h(n=%0d)", b, n), (n >= 10 * CPB && n <= 10 * CPB + 2), 1'b1);
        chk($sformatf("rx_done_%0h", b), RX_DONE, exp_rxd);
        chk($sformatf("rx_dout_%0h", b), RX_DOUT, exp_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        RESET = 1'b0;
        #20;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_tx_done", TX_DONE, 1'b0);
        chk("rst_rx_done", RX_DONE, 1'b0);
        chk("rst_rx_dout", RX_DOUT, 8'h00);
        chk("rst_line", dut.w_line, 1'b1);

        run_frame(8'h55, 1'b0, 1'b0, 8'h55, 1'b1);

        repeat (2) @(negedge CLK);
        run_frame(8'hA3, 1'b0, 1'b0, 8'hA3, 1'b1);
        // Request on the cycle right after TX_DONE rose.
        run_frame(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1);
        repeat (2) @(negedge CLK);
        run_frame(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1);

        repeat (2) @(negedge CLK);
        run_frame(8'hC5, 1'b1, 1'b0, 8'hC5, 1'b1);
        lows = 0;
        repeat (3 * CPB) begin
            @(negedge CLK);
            if (dut.w_line !== 1'b1) lows++;
        end
        chk("single_frame_lows", lows, 0);
        chk("single_frame_txd", TX_DONE, 1'b1);

        TX_DIN = 8'h81;
        TX_ENA = 1'b1;
        @(negedge CLK);
        TX_ENA = 1'b0;
        repeat (5 * CPB) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midrst_tx_done", TX_DONE, 1'b0);
        chk("midrst_rx_done", RX_DONE, 1'b0);
        chk("midrst_rx_dout", RX_DOUT, 8'h00);
        chk("midrst_line", dut.w_line, 1'b1);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("postrst_tx_done", TX_DONE, 1'b0);
        chk("postrst_rx_done", RX_DONE, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1);

        repeat (2) @(negedge CLK);
        run_frame(8'h5A, 1'b0, 1'b1, 8'h3C, 1'b0);

        repeat (2) @(negedge CLK);
        run_frame(8'h96, 1'b0, 1'b0, 8'h96, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
